hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Combines three controls:
  - Load-use hazard detection between the ID/EX and IF/ID registers.
  - Taken-branch flush.
  - Whole-pipeline freeze while the data memory has not acknowledged.
- Adds a post-reset boot hold, a memory-timeout error state and saturating stall/flush counters.
- Drives the PCWrite, IFIDWrite and IF_flush controls of the fetch stage and IF/ID register, plus bubble/hold controls for the downstream pipeline registers.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard sequencer state encoding and register constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } hz_state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot hold, load-use bubbles,
// branch flushes, data-memory freeze with timeout, and saturating event counters.
import pipeline_pkg::*;

module hazard_ctrl #(
  parameter int BOOT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IDEX_MemoryRead,
  input  logic [4:0]       IDEX_rd,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             branch,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IF_flush,
  output logic             IDEX_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output hz_state_t        dbg_state
);

  localparam logic [7:0]  BOOT_LAST = 8'(BOOT_CYCLES - 1);
  localparam logic [15:0] WAIT_MAX  = 16'(MEM_TIMEOUT);

  hz_state_t   state;
  logic [7:0]  boot_cnt;
  logic [15:0] wait_cnt;
  logic        lu;
  logic        frz;
  logic        stall_inc;
  logic        flush_inc;

  // dmem_req is the valid side of the memory handshake and dmem_ack the ready
  // side: an access completes only in a cycle where both are high, so a request
  // with no ack freezes the pipe, and a dropped request ends the wait like an ack.
  assign lu  = IDEX_MemoryRead && (IDEX_rd != REG_X0) &&
               ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));
  assign frz = dmem_req && !dmem_ack;

  assign dbg_state = state;

  always_comb begin
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IF_flush    = 1'b0;
    IDEX_bubble = 1'b0;
    pipe_hold   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    case (state)
      BOOT: begin
        IF_flush    = 1'b1;
        IDEX_bubble = 1'b1;
      end
      RUN, MEM_WAIT: begin
        // MEM_WAIT shares the RUN priority chain; once frz is gone the ack cycle behaves like RUN.
        if (frz) begin
          pipe_hold = 1'b1;
        end else if (lu) begin
          IDEX_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (branch) begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
          IF_flush  = 1'b1;
          flush_inc = 1'b1;
        end else begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
        end
      end
      default: begin
        pipe_hold = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      boot_cnt <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          boot_cnt <= boot_cnt + 8'd1;
          if (boot_cnt == BOOT_LAST) state <= RUN;
        end
        RUN: begin
          if (frz) begin
            state    <= MEM_WAIT;
            wait_cnt <= 16'd1;
          end
        end
        MEM_WAIT: begin
          if (!frz) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_MAX) begin
            state   <= ERROR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state   <= ERROR;
          mem_err <= 1'b1;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flush_inc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (BOOT_CYCLES=4, MEM_TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl;
  import pipeline_pkg::*;

  localparam int CNT_W = 4;

  // Output group order: {PCWrite, IFIDWrite, IF_flush, IDEX_bubble, pipe_hold}
  localparam logic [4:0] O_BOOT  = 5'b00110;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_FLUSH = 5'b11100;
  localparam logic [4:0] O_HOLD  = 5'b00001;

  logic             clk;
  logic             rst_n;
  logic             IDEX_MemoryRead;
  logic [4:0]       IDEX_rd;
  logic [4:0]       IFID_rs1;
  logic [4:0]       IFID_rs2;
  logic             branch;
  logic             dmem_req;
  logic             dmem_ack;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IF_flush;
  logic             IDEX_bubble;
  logic             pipe_hold;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  hz_state_t        dbg_state;

  int checks;
  int failures;

  hazard_ctrl #(
    .BOOT_CYCLES (4),
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IDEX_MemoryRead (IDEX_MemoryRead),
    .IDEX_rd         (IDEX_rd),
    .IFID_rs1        (IFID_rs1),
    .IFID_rs2        (IFID_rs2),
    .branch          (branch),
    .dmem_req        (dmem_req),
    .dmem_ack        (dmem_ack),
    .PCWrite         (PCWrite),
    .IFIDWrite       (IFIDWrite),
    .IF_flush        (IF_flush),
    .IDEX_bubble     (IDEX_bubble),
    .pipe_hold       (pipe_hold),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .dbg_state       (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply one cycle of inputs just after the falling edge, settle, return.
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic req,
                       input logic ack);
    @(negedge clk);
    IDEX_MemoryRead = mr;
    IDEX_rd         = rd;
    IFID_rs1        = rs1;
    IFID_rs2        = rs2;
    branch          = br;
    dmem_req        = req;
    dmem_ack        = ack;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {PCWrite, IFIDWrite, IF_flush, IDEX_bubble, pipe_hold};
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    IDEX_MemoryRead = 1'b0; IDEX_rd = '0; IFID_rs1 = '0; IFID_rs2 = '0;
    branch = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
    #12;

    // Reset state
    chk("rst_outs",  32'(outs()), 32'(O_BOOT));
    chk("rst_state", 32'(dbg_state), 32'(BOOT));
    chk("rst_err",   32'(mem_err), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_flush", 32'(flush_cnt), 32'd0);

    // Boot hold: 4 cycles of reset outputs, memory inputs ignored
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot_c1", 32'(outs()), 32'(O_BOOT));
    idle();
    chk("boot_c2", 32'(outs()), 32'(O_BOOT));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("boot_c3_req", 32'(outs()), 32'(O_BOOT));
    idle();
    chk("boot_c4", 32'(outs()), 32'(O_BOOT));
    chk("boot_c4_st", 32'(dbg_state), 32'(BOOT));
    idle();
    chk("run_c5", 32'(outs()), 32'(O_RUN));
    chk("run_c5_st", 32'(dbg_state), 32'(RUN));

    // Load-use on rs2
    drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
    chk("lu_rs2", 32'(outs()), 32'(O_STALL));
    idle();
    chk("lu_rs2_cnt", 32'(stall_cnt), 32'd1);
    chk("lu_after", 32'(outs()), 32'(O_RUN));
    // rd = x0 never stalls
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_x0", 32'(outs()), 32'(O_RUN));
    idle();
    chk("lu_x0_cnt", 32'(stall_cnt), 32'd1);
    // Non-load with matching rd never stalls
    drive(1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("nolu", 32'(outs()), 32'(O_RUN));
    // Load-use on rs1
    drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("lu_rs1", 32'(outs()), 32'(O_STALL));

    // Load-use plus branch: stall wins, branch taken next cycle
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("lu_br", 32'(outs()), 32'(O_STALL));
    drive(1'b0, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("br_outs", 32'(outs()), 32'(O_FLUSH));
    chk("br_flush0", 32'(flush_cnt), 32'd0);
    chk("br_stall3", 32'(stall_cnt), 32'd3);
    idle();
    chk("br_flush1", 32'(flush_cnt), 32'd1);

    // Memory wait: ack withheld 3 cycles, lu ignored while frozen
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mw_c1", 32'(outs()), 32'(O_HOLD));
    chk("mw_c1_st", 32'(dbg_state), 32'(RUN));
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("mw_c2", 32'(outs()), 32'(O_HOLD));
    chk("mw_c2_st", 32'(dbg_state), 32'(MEM_WAIT));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mw_c3", 32'(outs()), 32'(O_HOLD));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("mw_ack", 32'(outs()), 32'(O_RUN));
    chk("mw_frz_cnt", 32'(stall_cnt), 32'd3);
    idle();
    chk("mw_back_run", 32'(dbg_state), 32'(RUN));
    chk("mw_flush_keep", 32'(flush_cnt), 32'd1);

    // Same-cycle req and ack: no freeze
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk("reqack_outs", 32'(outs()), 32'(O_RUN));
    idle();
    chk("reqack_st", 32'(dbg_state), 32'(RUN));

    // Request dropped without ack returns to RUN
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("drop_outs", 32'(outs()), 32'(O_RUN));
    chk("drop_st", 32'(dbg_state), 32'(MEM_WAIT));
    idle();
    chk("drop_run", 32'(dbg_state), 32'(RUN));

    // Timeout (MEM_TIMEOUT = 4): ERROR entered after the fifth frozen cycle
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("to_c5_err", 32'(mem_err), 32'd0);
    chk("to_c5_st", 32'(dbg_state), 32'(MEM_WAIT));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("err_set", 32'(mem_err), 32'd1);
    chk("err_st", 32'(dbg_state), 32'(ERROR));
    chk("err_outs_ack", 32'(outs()), 32'(O_HOLD));
    drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("err_outs_lu", 32'(outs()), 32'(O_HOLD));
    idle();
    chk("err_sticky", 32'(mem_err), 32'd1);
    chk("err_stall", 32'(stall_cnt), 32'd3);
    chk("err_flush", 32'(flush_cnt), 32'd1);

    // Asynchronous reset mid-cycle from ERROR
    rst_n = 1'b0;
    #1;
    chk("arst_err", 32'(mem_err), 32'd0);
    chk("arst_st", 32'(dbg_state), 32'(BOOT));
    chk("arst_outs", 32'(outs()), 32'(O_BOOT));
    chk("arst_stall", 32'(stall_cnt), 32'd0);

    // Saturation: 2^4 + 3 load-use stalls after a fresh boot
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
    end
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat_stall_%0d", i), 32'(outs()), 32'(O_STALL));
      if (i == 15) chk("sat_at_15", 32'(stall_cnt), 32'd15);
    end
    idle();
    chk("sat_final", 32'(stall_cnt), 32'd15);
    chk("sat_flush0", 32'(flush_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
